// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the counter sequencer: FSM state encoding,
// requester/counter widths and a one-hot to index helper.
package counter_seq_pkg;

   localparam int NUM_REQ = 4;
   localparam int CNT_W   = 4;
   localparam int IDX_W   = 2;

   typedef enum logic [2:0] {
      ST_INIT = 3'd0,
      ST_IDLE = 3'd1,
      ST_LOAD = 3'd2,
      ST_RUN  = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
      logic [IDX_W-1:0] idx;
      idx = {IDX_W{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         if (oh[i]) begin
            idx = IDX_W'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/counter_sequencer_rr.sv
// Combinational round-robin arbiter over four requesters; the search starts
// one position after the previous owner.
module rr_arbiter4
   import counter_seq_pkg::*;
(
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   last_grant_i,
   output logic [NUM_REQ-1:0] winner_o
);

   logic             found_s;
   logic [IDX_W-1:0] idx_s;

   // Walk the ring from last_grant+1, wrapping by 2-bit truncation.
   always_comb begin
      winner_o = {NUM_REQ{1'b0}};
      found_s  = 1'b0;
      idx_s    = last_grant_i;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx_s = last_grant_i + IDX_W'(i);
         if (!found_s && req_i[idx_s]) begin
            winner_o[idx_s] = 1'b1;
            found_s         = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/counter_sequencer.sv
// Sequencer that arbitrates four requesters for one shared 4-bit up/down
// counter and runs a timed count of the winner's latched length.
module counter_sequencer
   import counter_seq_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ-1:0]   req_dir,
   input  logic [NUM_REQ*4-1:0] req_len,
   input  logic                 cancel,
   output logic [NUM_REQ-1:0]   grant,
   output logic [NUM_REQ-1:0]   done,
   output logic                 done_abort,
   output logic                 cnt_enable,
   output logic                 cnt_updown,
   output logic                 cnt_load,
   output logic                 cnt_set,
   output logic                 cnt_reset,
   output logic [CNT_W-1:0]     cnt_data,
   input  logic                 cnt_carry
);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic             dir_q, dir_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic             abort_q, abort_d;
   logic [NUM_REQ-1:0] winner_s;
   logic [IDX_W-1:0]   win_idx_s;

   rr_arbiter4 u_arb (
      .req_i        (req),
      .last_grant_i (last_q),
      .winner_o     (winner_s)
   );

   assign win_idx_s = onehot_to_idx(winner_s);

   // State and latched-run registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= ST_INIT;
         owner_q <= {IDX_W{1'b0}};
         last_q  <= 2'd3;
         dir_q   <= 1'b0;
         len_q   <= {CNT_W{1'b0}};
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         dir_q   <= dir_d;
         len_q   <= len_d;
         abort_q <= abort_d;
      end
   end

   // Next-state logic; cancel takes priority over terminal count.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      dir_d   = dir_q;
      len_d   = len_q;
      abort_d = abort_q;
      case (state_q)
         ST_INIT: begin
            state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (|req) begin
               state_d = ST_LOAD;
               owner_d = win_idx_s;
               dir_d   = req_dir[win_idx_s];
               len_d   = req_len[{win_idx_s, 2'b00} +: CNT_W];
               abort_d = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD, ST_RUN: begin
            if (cancel) begin
               state_d = ST_DONE;
               abort_d = 1'b1;
            end else if (cnt_carry) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            last_d  = owner_q;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // Moore output decode from registered state and latched fields only.
   always_comb begin
      grant      = {NUM_REQ{1'b0}};
      done       = {NUM_REQ{1'b0}};
      done_abort = 1'b0;
      cnt_enable = 1'b0;
      cnt_updown = 1'b0;
      cnt_load   = 1'b0;
      cnt_set    = 1'b0;
      cnt_reset  = 1'b0;
      cnt_data   = {CNT_W{1'b0}};
      case (state_q)
         ST_INIT: begin
            cnt_reset = 1'b1;
         end
         ST_IDLE: begin
            grant = {NUM_REQ{1'b0}};
         end
         ST_LOAD: begin
            grant      = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
            cnt_load   = 1'b1;
            cnt_updown = dir_q;
            cnt_data   = dir_q ? len_q : ~len_q;
         end
         ST_RUN: begin
            grant      = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
            cnt_enable = 1'b1;
            cnt_updown = dir_q;
         end
         ST_DONE: begin
            grant      = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
            done       = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
            done_abort = abort_q;
         end
         default: begin
            cnt_reset = 1'b1;
         end
      endcase
   end

endmodule
